// File: rtl/f32_bcd_seq.sv
// rtl/f32_bcd_seq.sv - sequential IEEE-754 float32 to fixed-point BCD converter
// Optional feature macro: F2B_EARLY_EXIT_EN (skip double dabble when the integer part is zero).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_ready, in_data   operand handshake (float32), accepted only in IDLE
//   out_valid, out_ready          result handshake, held in DONE until accepted
//   int_bcd                    INT_DIGITS BCD digits, least-significant digit in [3:0]
//   frac_bcd                   FRAC_DIGITS BCD digits, first digit after the point in the top nibble
//   sign, ovf, nan_inf         operand sign, integer overflow, exponent field all ones
module f32_bcd_seq #(
  parameter int INT_DIGITS  = 4,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*INT_DIGITS-1:0]   int_bcd,
  output logic [4*FRAC_DIGITS-1:0]  frac_bcd,
  output logic                      sign,
  output logic                      ovf,
  output logic                      nan_inf
);

  localparam int FW = 4 * FRAC_DIGITS;

  typedef enum logic [2:0] {IDLE, UNPACK, INT_DD, FRAC, DONE} state_t;

  state_t        state;
  logic [31:0]   op_q;
  logic [31:0]   bin_q;
  logic [39:0]   bcd_q;
  logic [23:0]   frac_q;
  logic [FW-1:0] fdig_q;
  logic [5:0]    cnt;
  logic          sign_q;
  logic          big_q;

  // Operand decode, consumed in UNPACK.
  logic [7:0]        exp_f;
  logic signed [9:0] e;
  logic [23:0]       m;
  logic [4:0]        lsh;
  logic [31:0]       int_u;
  logic [23:0]       frac_u;
  logic              big;

  always_comb begin
    exp_f  = op_q[30:23];
    e      = $signed({2'b00, exp_f}) - 10'sd127;
    m      = (exp_f == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
    // e+1 modulo 32; for e < -1 its negation is the right-shift distance.
    lsh    = e[4:0] + 5'd1;
    int_u  = 32'd0;
    frac_u = 24'd0;
    big    = 1'b0;
    if (e > 10'sd31)
      big = 1'b1;
    else if (e >= 10'sd24)
      int_u = {8'd0, m} << (e[4:0] - 5'd23);
    else if (e >= 10'sd0)
      int_u = {8'd0, m} >> (5'd23 - e[4:0]);
    if (e >= -10'sd1 && e <= 10'sd22)
      frac_u = m << lsh;
    else if (e >= -10'sd24 && e < -10'sd1)
      frac_u = m >> (5'd0 - lsh);
  end

  // One fraction digit per cycle: the carry out of f*10 above bit 23.
  logic [27:0]   prod;
  logic [FW-1:0] fdig_next;
  logic          hi_nz;

  always_comb begin
    prod      = {4'd0, frac_q} * 28'd10;
    fdig_next = (fdig_q << 4) | FW'(prod[27:24]);
    hi_nz     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i >= INT_DIGITS && bcd_q[4*i +: 4] != 4'd0)
        hi_nz = 1'b1;
    end
  end

  function automatic logic [39:0] dd_adj(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      int_bcd   <= '0;
      frac_bcd  <= '0;
      sign      <= 1'b0;
      ovf       <= 1'b0;
      nan_inf   <= 1'b0;
      op_q      <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      frac_q    <= '0;
      fdig_q    <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      big_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_q     <= in_data;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= op_q[31];
          big_q  <= big;
          bin_q  <= int_u;
          frac_q <= frac_u;
          bcd_q  <= '0;
          fdig_q <= '0;
          cnt    <= '0;
          if (exp_f == 8'hFF) begin
            // out_valid follows one cycle later, from DONE itself.
            int_bcd  <= '1;
            frac_bcd <= '1;
            sign     <= op_q[31];
            ovf      <= 1'b0;
            nan_inf  <= 1'b1;
            state    <= DONE;
          end
`ifdef F2B_EARLY_EXIT_EN
          else if (int_u == 32'd0)
            state <= FRAC;
`endif
          else
            state <= INT_DD;
        end
        INT_DD: begin
          {bcd_q, bin_q} <= {dd_adj(bcd_q), bin_q} << 1;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            cnt   <= '0;
            state <= FRAC;
          end
        end
        FRAC: begin
          frac_q <= prod[23:0];
          fdig_q <= fdig_next;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(FRAC_DIGITS - 1)) begin
            cnt       <= '0;
            int_bcd   <= bcd_q[4*INT_DIGITS-1:0];
            frac_bcd  <= fdig_next;
            sign      <= sign_q;
            ovf       <= big_q | hi_nz;
            nan_inf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f32_bcd_seq.sv
// tb/tb_f32_bcd_seq.sv - self-checking bench for f32_bcd_seq against a real-arithmetic model
module tb_f32_bcd_seq;

  localparam int ID = 4;
  localparam int FD = 4;
`ifdef F2B_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4*ID-1:0] int_bcd;
  logic [4*FD-1:0] frac_bcd;
  logic          sign;
  logic          ovf;
  logic          nan_inf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  f32_bcd_seq #(.INT_DIGITS(ID), .FRAC_DIGITS(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .int_bcd(int_bcd), .frac_bcd(frac_bcd),
    .sign(sign), .ovf(ovf), .nan_inf(nan_inf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic logic [15:0] bcd4(input longint v);
    logic [15:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Value-level model: magnitude as a real, integer part by floor, fraction
  // quantised to 2^-24 and truncated to four decimal places.
  task automatic ref_model(input logic [31:0] b, output logic [15:0] ib, output logic [15:0] fb,
                           output logic s, output logic o, output logic ni, output logic iz);
    int     ex;
    real    a, fr;
    longint n, fq, dd;
    ex = int'(b[30:23]);
    s  = b[31];
    if (ex == 255) begin
      ib = 16'hFFFF; fb = 16'hFFFF; o = 1'b0; ni = 1'b1; iz = 1'b0;
      return;
    end
    ni = 1'b0;
    a  = (ex == 0) ? 0.0 : (1.0 + real'(b[22:0]) / 8388608.0) * pow2(ex - 127);
    if (a >= 4294967296.0) begin
      o = 1'b1; ib = 16'h0000; fb = 16'h0000; iz = 1'b1;
      return;
    end
    n  = longint'($floor(a));
    fr = a - real'(n);
    fq = longint'($floor(fr * 16777216.0));
    dd = (fq * 10000) / 16777216;
    o  = (n >= 10000);
    iz = (n == 0);
    ib = bcd4(n % 10000);
    fb = bcd4(dd);
  endtask

  task automatic convert(input logic [31:0] b, input int stall, input string tag);
    logic [15:0] eib, efb;
    logic        es, eo, en, ez;
    int          lat, n, exp_lat;
    logic [36:0] hold;
    ref_model(b, eib, efb, es, eo, en, ez);
    exp_lat = en ? 2 : ((EARLY && ez) ? 1 + FD : 33 + FD);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " int_bcd"}, int_bcd, eib);
    chk({tag, " frac_bcd"}, frac_bcd, efb);
    chk({tag, " sign/ovf/nan"}, {sign, ovf, nan_inf}, {es, eo, en});
    chk({tag, " in_ready_done"}, in_ready, 0);
    hold = {out_valid, in_ready, int_bcd, frac_bcd, sign, ovf, nan_inf};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data  = $urandom;
      @(posedge clk);
      #1;
      chk({tag, " stall_hold"}, {out_valid, in_ready, int_bcd, frac_bcd, sign, ovf, nan_inf}, hold);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " release"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic reset_mid_intdd();
    @(negedge clk);
    in_data  = 32'h3FC00000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset outputs", {out_valid, int_bcd, frac_bcd, sign, ovf, nan_inf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset in_ready", {in_ready, out_valid}, 2'b10);
    repeat (40) @(posedge clk);
    #1;
    chk("midreset discarded", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  ex;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {out_valid, int_bcd, frac_bcd, sign, ovf, nan_inf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in_ready", {in_ready, out_valid}, 2'b10);

    convert(32'h3FC00000, 0, "1.5");
    convert(32'hC1440000, 0, "-12.25");
    convert(32'h3DCCCCCD, 0, "0.1");
    convert(32'h4640E400, 0, "12345");
    convert(32'h7F800000, 0, "inf");
    convert(32'h3F000000, 0, "0.5");
    convert(32'h00000000, 0, "zero");
    convert(32'h4F800000, 0, "2^32");
    convert(32'hC1440000, 5, "stall");
    reset_mid_intdd();
    convert(32'h3FC00000, 0, "1.5 after reset");

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 7))
        0:       ex = 8'd0;
        1:       ex = 8'd255;
        default: ex = 8'($urandom_range(98, 160));
      endcase
      r = {1'($urandom), ex, 23'($urandom)};
      convert(r, (k % 6 == 0) ? 2 : 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
